vram_arbiter: RTL

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vram_arbiter
// Description : Single-port video RAM arbiter between a fixed-latency scanout
//               fetch path and a host port. The scanout path has absolute
//               priority; the host is served during blanking only, or also
//               in any idle active-display cycle when cycle stealing is
//               enabled.
// Config      : define VRAM_ARB_STEAL_EN to enable host cycle stealing
//               during active display.
// Revision    : 1.0 - initial release
// ============================================================================
module vram_arbiter #(
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hblank_n,
  input  logic              vblank_n,
  input  logic              pix_req,
  input  logic [ADDR_W-1:0] pix_addr,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              host_timeout,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Wait counter must hold TIMEOUT+1 (saturation value).
  localparam int               CNT_W     = $clog2(TIMEOUT + 2);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_HOST = 2'd2
  } owner_t;

  owner_t            state;
  owner_t            state_nx;
  logic              blank;
  logic              host_elig;
  logic              scan_sel;
  logic              host_sel;
  logic              host_wait;
  logic              wait_over;
  logic [CNT_W-1:0]  wait_cnt;
  logic              timeout_q;
  logic              rd_pix_s1;
  logic              rd_host_s1;
  logic [DATA_W-1:0] pix_hold;
  logic [DATA_W-1:0] host_hold;

  assign blank = ~hblank_n | ~vblank_n;

`ifdef VRAM_ARB_STEAL_EN
  // Host may also borrow any active-display cycle the scanout leaves idle.
  assign host_elig = blank | ~pix_req;
`else
  // Host is locked out for the whole active-display period.
  assign host_elig = blank;
`endif

  // Owner decision for this cycle; the grant is issued in the deciding cycle.
  // A grant is never repeated in the cycle right after a grant, so a host that
  // drops its request one cycle after seeing host_gnt is served exactly once.
  always_comb begin
    state_nx = ST_IDLE;
    host_gnt = 1'b0;
    if (rst_n) begin
      if (pix_req) begin
        state_nx = ST_SCAN;
      end else if (host_req && host_elig && (state != ST_HOST)) begin
        state_nx = ST_HOST;
        host_gnt = 1'b1;
      end
    end
  end

  assign scan_sel = (state_nx == ST_SCAN);
  assign host_sel = (state_nx == ST_HOST);

  // Owner state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // RAM command registers: the access happens the cycle after the decision.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= host_sel & host_we;
      if (scan_sel) begin
        mem_addr <= pix_addr;
      end else if (host_sel) begin
        mem_addr <= host_addr;
        if (host_we) begin
          mem_wdata <= host_wdata;
        end
      end
    end
  end

  // Read-return pipeline: decision -> RAM access -> data strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_pix_s1   <= 1'b0;
      rd_host_s1  <= 1'b0;
      pix_valid   <= 1'b0;
      host_rvalid <= 1'b0;
    end else begin
      rd_pix_s1   <= scan_sel;
      rd_host_s1  <= host_sel & ~host_we;
      pix_valid   <= rd_pix_s1;
      host_rvalid <= rd_host_s1;
    end
  end

  // The RAM output is only meaningful in a strobe cycle; otherwise show the
  // last delivered word so both data outputs stay stable between strobes.
  assign pix_data   = pix_valid   ? mem_rdata : pix_hold;
  assign host_rdata = host_rvalid ? mem_rdata : host_hold;

  // Capture the last delivered read data for each requester.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_hold  <= '0;
      host_hold <= '0;
    end else begin
      pix_hold  <= pix_data;
      host_hold <= host_rdata;
    end
  end

  // A cycle counts as waiting when the host asks and is not granted.
  // wait_cnt holds the number of earlier consecutive waiting cycles, so the
  // current cycle is the one that exceeds TIMEOUT once wait_cnt reaches it.
  assign host_wait    = rst_n & host_req & ~host_gnt;
  assign wait_over    = host_wait & (wait_cnt >= CNT_LIMIT);
  assign host_timeout = timeout_q | wait_over;

  // Saturating count of consecutive host waiting cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (!host_wait) begin
      wait_cnt <= '0;
    end else if (wait_cnt != CNT_SAT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timeout_q <= 1'b0;
    end else if (wait_over) begin
      timeout_q <= 1'b1;
    end
  end

endmodule
`default_nettype wire
